// File: rtl/uart_rx_ctrl.sv
// Receive controller: watches a byte-level UART receiver, buffers completed
// bytes in a small FIFO and recovers the receiver when a frame stalls.
module uart_rx_ctrl #(
  parameter int DEPTH = 4,
  parameter int TMO   = 20
) (
  input  logic                     bclk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     rx_rdy,
  input  logic                     d_rdy,
  input  logic [7:0]               din,
  output logic                     rx_rst,
  input  logic                     rd_req,
  output logic                     rd_ack,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovr_err,
  output logic                     frm_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RECOVER, WAIT_IDLE} state_t;

  state_t          state_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic            rx_rdy_q;
  logic [AW-1:0]   wptr_reg;
  logic [AW-1:0]   rptr_reg;
  logic [7:0]      mem [DEPTH];

  logic            rise;
  logic            done;
  logic            tmo_hit;
  logic            wr_req;
  logic            wr_en;
  logic            rd_en;
  logic            ovr_set;
  logic            frm_set;
  logic [CW-1:0]   count_next;

  assign rise    = rx_rdy & ~rx_rdy_q;
  assign done    = (state_reg == BUSY) & rise;
  assign tmo_hit = (state_reg == BUSY) & ~rx_rdy & (tmo_cnt_reg == TW'(TMO - 1));
  assign wr_req  = done & d_rdy & en;
  assign rd_en   = rd_req & ~empty;
  // A full FIFO still accepts a byte when a pop frees the slot this cycle.
  assign wr_en   = wr_req & (~full | rd_en);
  assign ovr_set = wr_req & full & ~rd_en;
  assign frm_set = (done & ~d_rdy) | tmo_hit;

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en)
      count_next = count + CW'(1);
    else if (rd_en && !wr_en)
      count_next = count - CW'(1);
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tmo_cnt_reg <= '0;
      rx_rdy_q    <= 1'b1;
      rx_rst      <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy;
      rx_rst   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_rdy) begin
            state_reg   <= BUSY;
            tmo_cnt_reg <= '0;
          end
        end
        BUSY: begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          if (rise) begin
            state_reg <= IDLE;
          end else if (tmo_hit) begin
            state_reg <= RECOVER;
            rx_rst    <= 1'b1;
          end
        end
        RECOVER:   state_reg <= WAIT_IDLE;
        WAIT_IDLE: if (rx_rdy) state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

  // Storage has no reset so it maps onto distributed/block RAM.
  always_ff @(posedge bclk) begin
    if (wr_en)
      mem[wptr_reg] <= din;
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_ack   <= 1'b0;
      dout     <= 8'h00;
      ovr_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rd_ack <= rd_en;
      if (rd_en) begin
        dout     <= mem[rptr_reg];
        rptr_reg <= rptr_reg + AW'(1);
      end
      if (wr_en)
        wptr_reg <= wptr_reg + AW'(1);
      count   <= count_next;
      empty   <= (count_next == '0);
      full    <= (count_next == CW'(DEPTH));
      // Set events take priority over a same-cycle clear.
      ovr_err <= (ovr_err & ~err_clr) | ovr_set;
      frm_err <= (frm_err & ~err_clr) | frm_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue-based FIFO model predicts popped
// bytes, occupancy and error flags for directed and random frame traffic.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic        bclk = 1'b0;
  logic        rst, en, rx_rdy, d_rdy, rd_req, err_clr;
  logic [7:0]  din;
  logic        rx_rst, rd_ack, empty, full, ovr_err, frm_err;
  logic [7:0]  dout;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       exp_ovr = 1'b0;
  logic       exp_frm = 1'b0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .bclk(bclk), .rst(rst), .en(en), .rx_rdy(rx_rdy), .d_rdy(d_rdy), .din(din),
    .rx_rst(rx_rst), .rd_req(rd_req), .rd_ack(rd_ack), .dout(dout),
    .empty(empty), .full(full), .count(count),
    .ovr_err(ovr_err), .frm_err(frm_err), .err_clr(err_clr)
  );

  always #5 bclk = ~bclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every rd_ack pops the oldest predicted byte.
  always @(negedge bclk) begin
    if (!rst && rd_ack === 1'b1) begin
      acks++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_data: unexpected rd_ack with dout=0x%02h, expected no pop", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          bad++;
          $display("FAIL rd_data: got 0x%02h expected 0x%02h", dout, mon_exp);
        end else begin
          $display("pop 0x%02h ok", dout);
        end
      end
    end
  end

  task automatic status(input string tag);
    @(negedge bclk); #1;
    check({tag, "_count"}, int'(count), exp_q.size());
    check({tag, "_empty"}, int'(empty), int'(exp_q.size() == 0));
    check({tag, "_full"},  int'(full),  int'(exp_q.size() == DEPTH));
    check({tag, "_ovr"},   int'(ovr_err), int'(exp_ovr));
    check({tag, "_frm"},   int'(frm_err), int'(exp_frm));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_count"},  int'(count), 0);
    check({tag, "_empty"},  int'(empty), 1);
    check({tag, "_full"},   int'(full), 0);
    check({tag, "_rd_ack"}, int'(rd_ack), 0);
    check({tag, "_dout"},   int'(dout), 0);
    check({tag, "_rx_rst"}, int'(rx_rst), 0);
    check({tag, "_ovr"},    int'(ovr_err), 0);
    check({tag, "_frm"},    int'(frm_err), 0);
  endtask

  // One frame: rx_rdy low for L clock edges, then high with d_rdy=dv.
  task automatic send(input logic [7:0] b, input int L, input logic dv, input logic use_en,
                      input logic with_rd, input logic with_clr);
    int pulses, pulse_at, sz;
    logic timeout;
    pulses = 0; pulse_at = -1;
    timeout = (L >= TMO + 1);
    @(negedge bclk);
    en = use_en; rx_rdy = 1'b0; d_rdy = 1'b0; din = 8'($urandom);
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge bclk);
      if (rx_rst === 1'b1) begin pulses++; pulse_at = k; end
      if (k == L) begin
        sz = exp_q.size();
        if (timeout) exp_frm = 1'b1;
        if (with_clr) begin exp_ovr = 1'b0; exp_frm = 1'b0; end
        if (!timeout) begin
          if (!dv) exp_frm = 1'b1;
          else if (use_en) begin
            if (sz < DEPTH || (with_rd && sz > 0)) exp_q.push_back(b);
            else exp_ovr = 1'b1;
          end
        end
        rx_rdy = 1'b1; d_rdy = dv; din = b; rd_req = with_rd; err_clr = with_clr;
      end else if (k == L + 1) begin
        d_rdy = 1'b0; rd_req = 1'b0; err_clr = 1'b0; din = 8'($urandom);
      end
    end
    $display("frame 0x%02h L=%0d dv=%0b en=%0b rd=%0b clr=%0b", b, L, dv, use_en, with_rd, with_clr);
    check("rx_rst_pulses", pulses, timeout ? 1 : 0);
    if (timeout) check("rx_rst_at", pulse_at, TMO + 1);
  endtask

  task automatic rd(input int n);
    int a0, n_exp;
    @(negedge bclk);
    n_exp = (n < exp_q.size()) ? n : exp_q.size();
    a0 = acks;
    rd_req = 1'b1;
    repeat (n) @(negedge bclk);
    rd_req = 1'b0;
    @(negedge bclk); #1;
    $display("read burst n=%0d", n);
    check("rd_ack_count", acks - a0, n_exp);
  endtask

  task automatic clr_err();
    @(negedge bclk); err_clr = 1'b1;
    @(negedge bclk); err_clr = 1'b0;
    exp_ovr = 1'b0; exp_frm = 1'b0;
    $display("err_clr pulse");
  endtask

  initial begin
    logic [7:0] bytes3 [3];
    bytes3[0] = 8'h55; bytes3[1] = 8'hA3; bytes3[2] = 8'h0F;
    rst = 1'b1; en = 1'b1; rx_rdy = 1'b1; d_rdy = 1'b0; rd_req = 1'b0;
    err_clr = 1'b0; din = 8'h00;
    repeat (3) @(negedge bclk);
    #1 chk_reset("reset");
    @(negedge bclk); rst = 1'b0;

    // Three frames then a held read drains them in order.
    for (int i = 0; i < 3; i++) send(bytes3[i], 10, 1'b1, 1'b1, 1'b0, 1'b0);
    status("three_bytes");
    rd(3);
    status("drained");

    // Overflow: fifth byte dropped, flag sticky until cleared.
    for (int i = 1; i <= 5; i++) send(8'(i), $urandom_range(3, 8), 1'b1, 1'b1, 1'b0, 1'b0);
    status("overflow");
    rd(4);
    clr_err();
    status("ovr_cleared");

    // Full FIFO with a same-cycle pop accepts the byte.
    for (int i = 1; i <= 4; i++) send(8'(i), 4, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h05, 6, 1'b1, 1'b1, 1'b1, 1'b0);
    status("full_rw");
    rd(4);
    rd(2);
    check("dout_hold", int'(dout), 8'h05);

    // Stalled frame triggers recovery, then normal traffic resumes.
    send(8'hEE, 25, 1'b1, 1'b1, 1'b0, 1'b0);
    status("timeout");
    send(8'h3C, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    status("after_recover");
    rd(1);

    // Clear coincident with a framing error: the set wins.
    send(8'h99, 4, 1'b0, 1'b1, 1'b0, 1'b1);
    status("clr_vs_set");
    clr_err();
    status("frm_cleared");

    // Disabled receive discards the byte silently.
    send(8'h7E, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    status("en_off");

    // Reset mid-frame with two bytes held and a flag set.
    send(8'h11, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h22, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h33, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    status("pre_reset");
    @(negedge bclk); rx_rdy = 1'b0;
    repeat (3) @(negedge bclk);
    #2 rst = 1'b1;
    #1 chk_reset("async_reset");
    exp_q.delete(); exp_ovr = 1'b0; exp_frm = 1'b0;
    @(negedge bclk); rx_rdy = 1'b1; d_rdy = 1'b1; din = 8'hAA;
    @(negedge bclk); rst = 1'b0;
    @(negedge bclk); d_rdy = 1'b0;
    status("post_reset");

    // Random traffic against the queue model.
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        int L;
        L = ($urandom_range(0, 5) == 0) ? $urandom_range(TMO + 1, TMO + 5) : $urandom_range(1, TMO);
        send(8'($urandom), L, $urandom_range(0, 4) != 0, $urandom_range(0, 6) != 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      end else if (op <= 8) begin
        rd($urandom_range(1, 5));
      end else begin
        clr_err();
      end
      status("random");
    end
    rd(DEPTH + 1);
    status("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
